// File: rtl/l3_req_encoder_pkg.sv
// Shared widths, types and helpers for the L3 request encoder.
package l3_pkg;
  localparam int N_IN   = 32;
  localparam int CODE_W = 5;
  localparam int CNT_W  = 6;

  typedef logic [CODE_W-1:0] code_t;
  typedef logic [N_IN-1:0]   line_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  function automatic cnt_t popcount(input line_t v);
    cnt_t c;
    c = '0;
    for (int i = 0; i < N_IN; i++) c = c + cnt_t'(v[i]);
    return c;
  endfunction
endpackage

// File: rtl/l3_req_encoder_if.sv
// Request-side and code-side signals of the encoder; master drives requests.
// Handshake: a code transfers on a rising edge where valid && ready; while valid && !ready
// the encoder holds code and valid stable.
interface l3_req_encoder_if;
  import l3_pkg::*;

  logic  en;
  line_t req;
  logic  ready;
  code_t code;
  logic  valid;
  cnt_t  pend_cnt;
  logic  dup_err;

  modport master (output en, req, ready, input code, valid, pend_cnt, dup_err);
  modport slave  (input en, req, ready, output code, valid, pend_cnt, dup_err);
endinterface

// File: rtl/l3_req_encoder_prio_sel.sv
// Combinational priority selector: reports whether any line is set and the winning index.
module l3_prio_sel
  import l3_pkg::*;
#(
  parameter bit HIGH_FIRST = 1'b1
) (
  input  line_t vec_i,
  output logic  any_o,
  output code_t idx_o
);
  always_comb begin
    idx_o = '0;
    // Later matches overwrite earlier ones, so scan order sets the winner.
    for (int i = 0; i < N_IN; i++) begin
      if (HIGH_FIRST) begin
        if (vec_i[i]) idx_o = code_t'(i);
      end else begin
        if (vec_i[N_IN-1-i]) idx_o = code_t'(N_IN-1-i);
      end
    end
    any_o = |vec_i;
  end
endmodule

// File: rtl/l3_req_encoder.sv
// Sequential 32-to-5 encoder: collects request pulses into a pending set and
// emits the highest-priority pending index on a valid/ready output slot.
module l3_req_encoder
  import l3_pkg::*;
#(
  parameter bit HIGH_FIRST = 1'b1
) (
  input logic              clk,
  input logic              rst,
  l3_req_encoder_if.slave  bus
);
  line_t pending_q, pending_d;
  code_t code_q, code_d;
  logic  valid_q, valid_d;
  cnt_t  cnt_q;
  logic  dup_q, dup_d;

  line_t new_req, held_mask, cand;
  logic  slot_free, cand_any;
  code_t cand_idx;

  l3_prio_sel #(.HIGH_FIRST(HIGH_FIRST)) u_sel (
    .vec_i (cand),
    .any_o (cand_any),
    .idx_o (cand_idx)
  );

  always_comb begin
    new_req   = bus.req & {N_IN{bus.en}};
    slot_free = !valid_q || bus.ready;
    // Only a line stuck in a busy slot counts as held; one being accepted may re-request.
    held_mask = (valid_q && !bus.ready) ? (line_t'(1) << code_q) : '0;
    cand      = pending_q | new_req;

    pending_d = pending_q | (new_req & ~held_mask);
    code_d    = code_q;
    valid_d   = valid_q;
    dup_d     = dup_q | (|(new_req & (pending_q | held_mask)));

    if (slot_free) begin
      if (cand_any) begin
        code_d    = cand_idx;
        valid_d   = 1'b1;
        pending_d = cand & ~(line_t'(1) << cand_idx);
      end else if (bus.ready) begin
        valid_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      cnt_q     <= '0;
      dup_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      cnt_q     <= popcount(pending_d);
      dup_q     <= dup_d;
    end
  end

  assign bus.code     = code_q;
  assign bus.valid    = valid_q;
  assign bus.pend_cnt = cnt_q;
  assign bus.dup_err  = dup_q;
endmodule

// File: tb/tb_l3_req_encoder.sv
// Directed bench for l3_req_encoder: vector table plus hand-written multi-cycle sequences.
module tb_l3_req_encoder;
  import l3_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  l3_req_encoder_if bus ();

  l3_req_encoder #(.HIGH_FIRST(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] req;
    logic        en;
    logic        ready;
    logic        exp_valid;
    logic [4:0]  exp_code;
    logic [5:0]  exp_cnt;
    logic        exp_dup;
    logic        chk_dec;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic drive(input logic [31:0] r, input logic e, input logic rd);
    bus.req   = r;
    bus.en    = e;
    bus.ready = rd;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [4:0] c,
                            input logic [5:0] cnt, input logic d);
    check({tag, ".valid"}, 32'(bus.valid), 32'(v));
    if (v) check({tag, ".code"}, 32'(bus.code), 32'(c));
    check({tag, ".pend_cnt"}, 32'(bus.pend_cnt), 32'(cnt));
    check({tag, ".dup_err"}, 32'(bus.dup_err), 32'(d));
  endtask

  function automatic vec_t mk(input logic [31:0] r, input logic e, input logic rd,
                              input logic v, input logic [4:0] c, input logic [5:0] cnt,
                              input logic dec);
    vec_t t;
    t.req = r; t.en = e; t.ready = rd; t.exp_valid = v; t.exp_code = c;
    t.exp_cnt = cnt; t.exp_dup = 1'b0; t.chk_dec = dec;
    return t;
  endfunction

  initial begin
    logic [31:0] y;
    n_cmp = 0;
    n_err = 0;
    drive('0, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    check("por.code", 32'(bus.code), 32'd0);
    expect_out("por", 1'b0, 5'd0, 6'd0, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    expect_out("idle", 1'b0, 5'd0, 6'd0, 1'b0);

    // Single request and latency.
    drive(32'h1 << 17, 1'b1, 1'b1); tick();
    expect_out("single", 1'b1, 5'd17, 6'd0, 1'b0);
    // Re-request of the line being accepted this edge is fresh.
    drive(32'h1 << 17, 1'b1, 1'b1); tick();
    expect_out("refresh", 1'b1, 5'd17, 6'd0, 1'b0);
    drive('0, 1'b1, 1'b1); tick();
    expect_out("single_done", 1'b0, 5'd0, 6'd0, 1'b0);

    // Priority burst with initial backpressure.
    drive(32'h8000_0011, 1'b1, 1'b0); tick();
    expect_out("burst0", 1'b1, 5'd31, 6'd2, 1'b0);
    drive('0, 1'b1, 1'b0); tick();
    expect_out("burst_hold", 1'b1, 5'd31, 6'd2, 1'b0);
    bus.ready = 1'b1; tick();
    expect_out("burst1", 1'b1, 5'd4, 6'd1, 1'b0);
    tick();
    expect_out("burst2", 1'b1, 5'd0, 6'd0, 1'b0);
    tick();
    expect_out("burst_done", 1'b0, 5'd0, 6'd0, 1'b0);

    // Backpressure with new arrivals.
    drive(32'h1 << 9, 1'b1, 1'b0); tick();
    expect_out("bp_load", 1'b1, 5'd9, 6'd0, 1'b0);
    drive((32'h1 << 3) | (32'h1 << 20), 1'b1, 1'b0); tick();
    expect_out("bp_merge", 1'b1, 5'd9, 6'd2, 1'b0);
    drive('0, 1'b1, 1'b0); tick();
    expect_out("bp_hold", 1'b1, 5'd9, 6'd2, 1'b0);
    bus.ready = 1'b1; tick();
    expect_out("bp_20", 1'b1, 5'd20, 6'd1, 1'b0);
    tick();
    expect_out("bp_3", 1'b1, 5'd3, 6'd0, 1'b0);
    tick();
    expect_out("bp_done", 1'b0, 5'd0, 6'd0, 1'b0);

    // Duplicate on held line, and ignored requests with en=0.
    drive(32'h1 << 9, 1'b1, 1'b0); tick();
    expect_out("dup_load", 1'b1, 5'd9, 6'd0, 1'b0);
    drive(32'hFFFF_FFFF, 1'b0, 1'b0); tick();
    expect_out("en_off", 1'b1, 5'd9, 6'd0, 1'b0);
    drive(32'h1 << 9, 1'b1, 1'b0); tick();
    expect_out("dup_set", 1'b1, 5'd9, 6'd0, 1'b1);
    drive('0, 1'b1, 1'b1); tick();
    expect_out("dup_once", 1'b0, 5'd0, 6'd0, 1'b1);
    drive(32'hFFFF_FFFF, 1'b0, 1'b1); tick();
    expect_out("dup_sticky", 1'b0, 5'd0, 6'd0, 1'b1);

    // Asynchronous reset with five lines pending.
    drive(32'h0000_003F, 1'b1, 1'b0); tick();
    expect_out("rst_fill", 1'b1, 5'd5, 6'd5, 1'b1);
    drive('0, 1'b1, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("rst_async.code", 32'(bus.code), 32'd0);
    expect_out("rst_async", 1'b0, 5'd0, 6'd0, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    expect_out("rst_after", 1'b0, 5'd0, 6'd0, 1'b0);

    // Table: sweep every line, then a short multi-bit drain including en=0.
    for (int k = 0; k < 32; k++) vecs.push_back(mk(32'h1 << k, 1'b1, 1'b1, 1'b1, 5'(k), 6'd0, 1'b1));
    vecs.push_back(mk(32'h0, 1'b1, 1'b1, 1'b0, 5'd31, 6'd0, 1'b0));
    vecs.push_back(mk(32'h0000_00F0, 1'b1, 1'b1, 1'b1, 5'd7, 6'd3, 1'b0));
    vecs.push_back(mk(32'h0, 1'b1, 1'b1, 1'b1, 5'd6, 6'd2, 1'b0));
    vecs.push_back(mk(32'h0000_0001, 1'b0, 1'b1, 1'b1, 5'd5, 6'd1, 1'b0));
    vecs.push_back(mk(32'h0, 1'b1, 1'b1, 1'b1, 5'd4, 6'd0, 1'b0));
    vecs.push_back(mk(32'h0, 1'b1, 1'b1, 1'b0, 5'd4, 6'd0, 1'b0));

    foreach (vecs[i]) begin
      drive(vecs[i].req, vecs[i].en, vecs[i].ready);
      tick();
      expect_out($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_code,
                 vecs[i].exp_cnt, vecs[i].exp_dup);
      if (!vecs[i].exp_valid) check($sformatf("vec%0d.code_kept", i), 32'(bus.code), 32'(vecs[i].exp_code));
      if (vecs[i].chk_dec) begin
        y = 32'h1 << bus.code;
        check($sformatf("vec%0d.decode", i), 32'(y[vecs[i].exp_code]), 32'd1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
